// File: rtl/dll_priority_enc_pipe.sv
// Pipelined leading-one detector over in[WIDTH-1:MIN_BIT], MSB first, split across STAGES registers.
// Optional peak-hold tracker is built when DLL_PRIO_PEAK_HOLD_EN is defined.
module dll_priority_enc_pipe #(
    parameter int WIDTH    = 36,
    parameter int MIN_BIT  = 11,
    parameter int STAGES   = 2,
    parameter int NONE_VAL = 10,
    parameter int POS_W    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             peak_clear,
    output logic [POS_W-1:0] out_pos,
    output logic             out_found,
    output logic             out_valid,
    output logic [POS_W-1:0] peak_pos,
    output logic             peak_valid
);

    localparam int NBITS = WIDTH - MIN_BIT;
    localparam int SEG   = (NBITS + STAGES - 1) / STAGES;
    localparam logic [POS_W-1:0] NONE_POS = POS_W'(NONE_VAL);

    // Stage inputs (what stage k sees) and stage registers (what stage k holds)
    logic             stg_valid  [STAGES];
    logic             stg_found  [STAGES];
    logic [POS_W-1:0] stg_pos    [STAGES];
    logic [WIDTH-1:0] stg_data   [STAGES];
    logic             found_next [STAGES];
    logic [POS_W-1:0] pos_next   [STAGES];

    logic             valid_reg  [STAGES];
    logic             found_reg  [STAGES];
    logic [POS_W-1:0] pos_reg    [STAGES];
    logic [WIDTH-1:0] data_reg   [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int SEG_HI     = WIDTH - 1 - gi * SEG;
            localparam int SEG_LO_RAW = SEG_HI - SEG + 1;
            // Last segment always extends down to MIN_BIT and absorbs the remainder
            localparam int SEG_LO     = (gi == STAGES - 1 || SEG_LO_RAW < MIN_BIT) ? MIN_BIT : SEG_LO_RAW;

            logic             seg_found;
            logic [POS_W-1:0] seg_pos;

            if (gi == 0) begin : g_head
                assign stg_valid[gi] = in_valid;
                assign stg_found[gi] = 1'b0;
                assign stg_pos[gi]   = NONE_POS;
                assign stg_data[gi]  = in;
            end else begin : g_tail
                assign stg_valid[gi] = valid_reg[gi-1];
                assign stg_found[gi] = found_reg[gi-1];
                assign stg_pos[gi]   = pos_reg[gi-1];
                assign stg_data[gi]  = data_reg[gi-1];
            end

            always_comb begin
                seg_found = stg_found[gi];
                seg_pos   = stg_pos[gi];
                if (!stg_found[gi]) begin
                    // Ascending scan so the highest set bit is the last one written
                    for (int b = SEG_LO; b <= SEG_HI; b++) begin
                        if (stg_data[gi][b]) begin
                            seg_found = 1'b1;
                            seg_pos   = POS_W'(b);
                        end
                    end
                end
            end

            assign found_next[gi] = seg_found;
            assign pos_next[gi]   = seg_pos;
        end
    endgenerate

    // found/pos only load on valid samples, so the last stage holds across bubbles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k] <= 1'b0;
                found_reg[k] <= 1'b0;
                pos_reg[k]   <= NONE_POS;
                data_reg[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k] <= stg_valid[k];
                if (stg_valid[k]) begin
                    found_reg[k] <= found_next[k];
                    pos_reg[k]   <= pos_next[k];
                    data_reg[k]  <= stg_data[k];
                end
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_found = found_reg[STAGES-1];
    assign out_pos   = pos_reg[STAGES-1];

`ifdef DLL_PRIO_PEAK_HOLD_EN
    logic [POS_W-1:0] peak_pos_reg;
    logic             peak_valid_reg;
    logic             result_hit;

    assign result_hit = out_valid && out_found;

    // A clear coincident with a qualifying result restarts the window with that result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_pos_reg   <= NONE_POS;
            peak_valid_reg <= 1'b0;
        end else if (peak_clear) begin
            peak_pos_reg   <= result_hit ? out_pos : NONE_POS;
            peak_valid_reg <= result_hit;
        end else if (result_hit && (!peak_valid_reg || out_pos > peak_pos_reg)) begin
            peak_pos_reg   <= out_pos;
            peak_valid_reg <= 1'b1;
        end
    end

    assign peak_pos   = peak_pos_reg;
    assign peak_valid = peak_valid_reg;
`else
    logic peak_clear_unused;
    assign peak_clear_unused = peak_clear;
    assign peak_pos          = NONE_POS;
    assign peak_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_dll_priority_enc_pipe.sv
// Directed bench for dll_priority_enc_pipe at default parameters (latency 2).
// Peak-hold checks follow DLL_PRIO_PEAK_HOLD_EN; otherwise the tied-off peak outputs are checked.
module tb_dll_priority_enc_pipe;

    logic        clk;
    logic        reset_n;
    logic [35:0] in;
    logic        in_valid;
    logic        peak_clear;
    logic [5:0]  out_pos;
    logic        out_found;
    logic        out_valid;
    logic [5:0]  peak_pos;
    logic        peak_valid;

    int n_checks = 0;
    int n_fail   = 0;

    dll_priority_enc_pipe dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (in),
        .in_valid   (in_valid),
        .peak_clear (peak_clear),
        .out_pos    (out_pos),
        .out_found  (out_found),
        .out_valid  (out_valid),
        .peak_pos   (peak_pos),
        .peak_valid (peak_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One valid pulse, then wait out the two-cycle latency; result is visible on return
    task automatic send(input logic [35:0] vec);
        in       = vec;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        $display("sample in=%09h -> valid=%0b pos=%0d found=%0b", vec, out_valid, out_pos, out_found);
    endtask

    task automatic chk_out(input string tag, input logic [5:0] pos, input logic found);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_pos"}, out_pos, pos);
        chk({tag, "_found"}, out_found, found);
    endtask

    initial begin
        reset_n    = 1'b0;
        in         = '0;
        in_valid   = 1'b0;
        peak_clear = 1'b0;
        step();
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pos", out_pos, 6'd10);
        chk("rst_out_found", out_found, 1'b0);
        chk("rst_peak_pos", peak_pos, 6'd10);
        chk("rst_peak_valid", peak_valid, 1'b0);
        #3 reset_n = 1'b1;
        step();

        // Top bit beats a lower-segment bit; output holds during the following bubble
        send(36'h800001000);
        chk_out("b35_b12", 6'd35, 1'b1);
        step();
        chk("hold_valid", out_valid, 1'b0);
        chk("hold_pos", out_pos, 6'd35);
        chk("hold_found", out_found, 1'b1);

        send(36'h000001000);
        chk_out("b12", 6'd12, 1'b1);
        send(36'h000000800);
        chk_out("b11_min", 6'd11, 1'b1);
        send(36'h000000020);
        chk_out("b5_ignored", 6'd10, 1'b0);
        send(36'h000000000);
        chk_out("zero", 6'd10, 1'b0);
        send(36'h0000007FF);
        chk_out("below_min_only", 6'd10, 1'b0);

        // Back-to-back samples straddling the segment boundary
        in       = 36'h000800000;
        in_valid = 1'b1;
        step();
        in       = 36'h000400000;
        step();
        chk_out("btb_b23", 6'd23, 1'b1);
        in       = 36'h000000000;
        step();
        chk_out("btb_b22", 6'd22, 1'b1);
        in_valid = 1'b0;
        step();
        chk_out("btb_none", 6'd10, 1'b0);
        step();
        chk("btb_bubble", out_valid, 1'b0);

        send(36'h000600800);
        chk_out("b22_b21_b11", 6'd22, 1'b1);

        // Asynchronous reset with two samples in flight
        in       = 36'h040000000;
        in_valid = 1'b1;
        step();
        in = 36'h000100000;
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_pos", out_pos, 6'd10);
        chk("arst_found", out_found, 1'b0);
        in_valid = 1'b0;
        step();
        #3 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_valid", out_valid, 1'b0);
        end

`ifdef DLL_PRIO_PEAK_HOLD_EN
        send(36'h000100000);
        send(36'h040000000);
        step();
        chk("peak_after_30", peak_pos, 6'd30);
        send(36'h002000000);
        step();
        chk("peak_20_30_25", peak_pos, 6'd30);
        chk("peak_20_30_25_v", peak_valid, 1'b1);
        send(36'h000008000);
        peak_clear = 1'b1;
        step();
        peak_clear = 1'b0;
        chk("peak_clr_with_15", peak_pos, 6'd15);
        chk("peak_clr_with_15_v", peak_valid, 1'b1);
        send(36'h000000000);
        step();
        chk("peak_notfound_kept", peak_pos, 6'd15);
        send(36'h000001000);
        step();
        chk("peak_lower_kept", peak_pos, 6'd15);
        peak_clear = 1'b1;
        step();
        peak_clear = 1'b0;
        chk("peak_clr_alone_v", peak_valid, 1'b0);
        chk("peak_clr_alone_pos", peak_pos, 6'd10);
`else
        send(36'h040000000);
        step();
        chk("tied_peak_pos", peak_pos, 6'd10);
        chk("tied_peak_valid", peak_valid, 1'b0);
        send(36'h000008000);
        peak_clear = 1'b1;
        step();
        peak_clear = 1'b0;
        chk("tied_peak_pos_clr", peak_pos, 6'd10);
        chk("tied_peak_valid_clr", peak_valid, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dll_priority_enc_pipe.md
# dll_priority_enc_pipe

Parametrised, pipelined leading-one detector for the DLL path, generalising the two-stage fixed 36-bit encoder. It scans a configurable bit range of the input, most significant bit first. The scan is split across a configurable number of register stages. Each result carries a valid flag and a found flag, and an optional peak-hold tracker follows the largest position over an accumulation window. It sits between the DLL correlation/threshold logic and the code-phase adjustment logic.

## Interface
- WIDTH, 36, input vector width.
- MIN_BIT, 11, lowest bit examined; bits below are ignored.
- STAGES, 2, pipeline depth; 1 ≤ STAGES ≤ WIDTH-MIN_BIT.
- NONE_VAL, 10, position reported when no examined bit is set.
- POS_W, 6, position width; must hold WIDTH-1 and NONE_VAL.
- clk  input  1  clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  vector to encode.
- in_valid  input  1  in is sampled this cycle.
- peak_clear  input  1  restart peak window (peak-hold build only; ignored otherwise).
- out_pos  output  POS_W  index of highest set bit in [WIDTH-1:MIN_BIT], or NONE_VAL.
- out_found  output  1  an examined bit was set.
- out_valid  output  1  out_pos/out_found updated this cycle.
- peak_pos  output  POS_W  largest found position since last clear.
- peak_valid  output  1  peak_pos holds a real position.

## Operation
- Examined range N = WIDTH-MIN_BIT bits is split into STAGES segments, MSB first.
- Segments 0..STAGES-2 are ceil(N/STAGES) bits each; the last segment takes the remainder.
- Stage k registers (valid, found, pos) and the not-yet-scanned lower bits of the sample.
- If found is already set, stage k passes pos through unchanged.
- Otherwise stage k searches segment k MSB-first; on a hit it sets found and pos to the absolute bit index.
- If the final stage has found=0: out_pos=NONE_VAL, out_found=0.
- Lower-segment bits are delayed alongside their sample; the pipeline carries no cross-sample state.
- Full throughput: one sample per cycle, no backpressure.
- in_valid=0 inserts a bubble that propagates as valid=0.
- When out_valid=0, out_pos/out_found hold their last value.
- Reset (reset_n=0, async) clears all valid bits. out_pos=NONE_VAL, out_found=0, out_valid=0, peak_pos=NONE_VAL, peak_valid=0.
- Reset mid-operation discards every in-flight sample; none emerges after release.

## Timing
- Latency: exactly STAGES cycles from the in_valid edge to the out_valid edge.
- Sample on cycle t appears on cycle t+STAGES.
- Output order equals input order.
- Outputs are registered; no combinational path from in to outputs.
- Peak update happens on the cycle after out_valid=1 and out_found=1:
  - if peak_valid=0 or out_pos>peak_pos, then peak_pos←out_pos and peak_valid←1.
- peak_clear=1 at the same edge as a qualifying result: clear applies first, then the result loads. Result: peak_pos=that result, peak_valid=1.
- peak_clear=1 with no qualifying result: peak_pos←NONE_VAL, peak_valid←0.
- Results with out_found=0 never change the peak.

## Configuration
- DLL_PRIO_PEAK_HOLD_EN defined: peak tracker built as described above.
- DLL_PRIO_PEAK_HOLD_EN undefined:
  - peak_pos is tied to NONE_VAL and peak_valid to 0.
  - peak_clear is ignored.
  - the port list is unchanged.

## Test plan
All tests use default parameters (segments bits 35..23 and 22..11), so latency is 2.
- Bits 35 and 12 set, in_valid pulse on cycle 0 -> cycle 2: out_valid=1, out_pos=35, out_found=1; cycle 3: out_valid=0, out_pos still 35.
- in=36'h000001000 (bit 12 only) -> out_pos=12, out_found=1; in=36'h000000800 (bit 11) -> out_pos=11.
- in=36'h000000020 (bit 5 only) or all-zero -> out_pos=10, out_found=0, out_valid=1.
- Back-to-back valid inputs with top bits 23, 22, none on cycles 0-2 -> outputs 23/1, 22/1, 10/0 on cycles 2, 3, 4.
- Drive valid on cycles 0 and 1, then assert reset_n=0 mid-cycle 1 -> out_valid=0 and out_pos=10 immediately; no out_valid for 4 cycles after release.
- Peak build, results 20, 30, 25 -> peak_pos=30. peak_clear coincident with result 15 -> peak_pos=15, peak_valid=1. Clear alone -> peak_valid=0, peak_pos=10. Macro undefined -> peak_pos=10, peak_valid=0 throughout.
